// File: rtl/alu_eis.sv
// alu_eis: iterative extended-instruction ALU (MUL, DIV, ASH, ASHC).
// Handles one bit per clock on a 2W-bit datapath split across register pairs R and R|1.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   start       begin an operation (accepted in IDLE or DONE only)
//   op          00 MUL, 01 DIV, 10 ASH, 11 ASHC
//   a           multiplier / divisor / shift count (a[5:0], signed)
//   b_hi, b_lo  even register R and odd register R|1
//   ps          processor state at start
//   busy        high while an operation is running
//   done        one-cycle pulse when results become valid
//   d_hi, d_lo  results for R and R|1
//   psr         {ps[7:4], N, Z, V, C}
module alu_eis #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_hi,
  input  logic [W-1:0] b_lo,
  input  logic [7:0]   ps,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d_hi,
  output logic [W-1:0] d_lo,
  output logic [7:0]   psr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_ASH  = 2'b10;
  localparam logic [1:0] OP_ASHC = 2'b11;

  localparam logic [5:0]   WCNT   = 6'(W);
  localparam logic [W-1:0] MINMAG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]   state;
  logic [1:0]   op_q;
  logic [3:0]   ps_q;
  logic [W-1:0] hold_hi;
  logic [W-1:0] hold_lo;

  // Shared datapath. MUL: Booth {acc, lsr, bq} with acc one bit wider.
  // DIV: partial remainder in acc, quotient shifts into lsr.
  // ASH/ASHC: operand in acc[W-1:0] (and lsr for ASHC).
  logic [W:0]   acc;
  logic [W-1:0] lsr;
  logic         bq;
  logic [W-1:0] opd;
  logic [5:0]   cnt;
  logic         neg_q;
  logic         neg_r;
  logic         dz;
  logic         ovf;
  logic         left;
  logic         zsh;
  logic         cf;
  logic         vf;

  logic unused_ps;
  assign unused_ps = ^ps[3:0];

  // Operand preparation at the accepting edge.
  logic [2*W-1:0] dvd;
  logic [2*W-1:0] dmag;
  logic [W-1:0]   dvs;
  logic [5:0]     mag;

  always_comb begin
    dvd  = {b_hi, b_lo};
    dmag = b_hi[W-1] ? (~dvd + 1'b1) : dvd;
    dvs  = a[W-1] ? (~a + 1'b1) : a;
    mag  = a[5] ? (~a[5:0] + 6'd1) : a[5:0];
  end

  // One iteration step.
  logic [W:0]   n_acc;
  logic [W-1:0] n_lsr;
  logic         n_bq;
  logic         n_cf;
  logic         n_vf;
  logic [W:0]   mext;
  logic [W:0]   sum;
  logic [W:0]   shv;

  always_comb begin
    n_acc = acc;
    n_lsr = lsr;
    n_bq  = bq;
    n_cf  = cf;
    n_vf  = vf;
    mext  = {opd[W-1], opd};
    sum   = acc;
    shv   = {acc[W-1:0], lsr[W-1]};
    case (op_q)
      OP_MUL: begin
        case ({lsr[0], bq})
          2'b01:   sum = acc + mext;
          2'b10:   sum = acc - mext;
          default: sum = acc;
        endcase
        n_acc = {sum[W], sum[W:1]};
        n_lsr = {sum[0], lsr[W-1:1]};
        n_bq  = lsr[0];
      end
      OP_DIV: begin
        if (!dz) begin
          if (shv >= {1'b0, opd}) begin
            n_acc = shv - {1'b0, opd};
            n_lsr = {lsr[W-2:0], 1'b1};
          end else begin
            n_acc = shv;
            n_lsr = {lsr[W-2:0], 1'b0};
          end
        end
      end
      OP_ASH: begin
        if (!zsh) begin
          if (left) begin
            n_cf  = acc[W-1];
            n_acc = {1'b0, acc[W-2:0], 1'b0};
            if (acc[W-1] != acc[W-2]) n_vf = 1'b1;
          end else begin
            n_cf  = acc[0];
            n_acc = {1'b0, acc[W-1], acc[W-1:1]};
          end
        end
      end
      default: begin
        if (!zsh) begin
          if (left) begin
            n_cf  = acc[W-1];
            n_acc = {1'b0, acc[W-2:0], lsr[W-1]};
            n_lsr = {lsr[W-2:0], 1'b0};
            if (acc[W-1] != acc[W-2]) n_vf = 1'b1;
          end else begin
            n_cf  = lsr[0];
            n_acc = {1'b0, acc[W-1], acc[W-1:1]};
            n_lsr = {acc[0], lsr[W-1:1]};
          end
        end
      end
    endcase
  end

  // Final result formed from the values produced by the last step.
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic           r_n;
  logic           r_z;
  logic           r_v;
  logic           r_c;
  logic [2*W-1:0] prod;
  logic [W-1:0]   qmag;
  logic [W-1:0]   rmag;
  logic [W-1:0]   qs;
  logic           fit;

  always_comb begin
    r_hi = hold_hi;
    r_lo = hold_lo;
    r_n  = 1'b0;
    r_z  = 1'b0;
    r_v  = 1'b0;
    r_c  = 1'b0;
    prod = {n_acc[W-1:0], n_lsr};
    qmag = n_lsr;
    rmag = n_acc[W-1:0];
    qs   = neg_q ? (~qmag + 1'b1) : qmag;
    // Magnitude MINMAG only fits when the quotient is negative.
    fit  = neg_q ? (qmag <= MINMAG) : ~qmag[W-1];
    case (op_q)
      OP_MUL: begin
        r_hi = prod[2*W-1:W];
        r_lo = prod[W-1:0];
        r_n  = prod[2*W-1];
        r_z  = (prod == '0);
        r_c  = ~((&prod[2*W-1:W-1]) | ~(|prod[2*W-1:W-1]));
      end
      OP_DIV: begin
        if (dz) begin
          r_v = 1'b1;
          r_c = 1'b1;
        end else if (ovf || !fit) begin
          r_v = 1'b1;
        end else begin
          r_hi = qs;
          r_lo = neg_r ? (~rmag + 1'b1) : rmag;
          r_n  = qs[W-1];
          r_z  = (qs == '0);
        end
      end
      OP_ASH: begin
        r_hi = n_acc[W-1:0];
        r_lo = hold_lo;
        r_n  = n_acc[W-1];
        r_z  = (n_acc[W-1:0] == '0);
        r_v  = n_vf;
        r_c  = n_cf;
      end
      default: begin
        r_hi = n_acc[W-1:0];
        r_lo = n_lsr;
        r_n  = n_acc[W-1];
        r_z  = ({n_acc[W-1:0], n_lsr} == '0);
        r_v  = n_vf;
        r_c  = n_cf;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      ps_q    <= '0;
      hold_hi <= '0;
      hold_lo <= '0;
      acc     <= '0;
      lsr     <= '0;
      bq      <= 1'b0;
      opd     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      ovf     <= 1'b0;
      left    <= 1'b0;
      zsh     <= 1'b0;
      cf      <= 1'b0;
      vf      <= 1'b0;
      d_hi    <= '0;
      d_lo    <= '0;
      psr     <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          acc <= n_acc;
          lsr <= n_lsr;
          bq  <= n_bq;
          cf  <= n_cf;
          vf  <= n_vf;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= ST_DONE;
            d_hi  <= r_hi;
            d_lo  <= r_lo;
            psr   <= {ps_q, r_n, r_z, r_v, r_c};
          end
        end
        default: begin
          if (start) begin
            state   <= ST_RUN;
            op_q    <= op;
            ps_q    <= ps[7:4];
            hold_hi <= b_hi;
            hold_lo <= b_lo;
            bq      <= 1'b0;
            cf      <= 1'b0;
            vf      <= 1'b0;
            neg_q   <= b_hi[W-1] ^ a[W-1];
            neg_r   <= b_hi[W-1];
            dz      <= (a == '0);
            ovf     <= (a != '0) && (dmag[2*W-1:W] >= dvs);
            left    <= ~a[5];
            zsh     <= (mag == 6'd0);
            case (op)
              OP_MUL: begin
                acc <= '0;
                lsr <= b_hi;
                opd <= a;
                cnt <= WCNT;
              end
              OP_DIV: begin
                acc <= {1'b0, dmag[2*W-1:W]};
                lsr <= dmag[W-1:0];
                opd <= dvs;
                cnt <= (a == '0) ? 6'd1 : WCNT;
              end
              default: begin
                acc <= {1'b0, b_hi};
                lsr <= b_lo;
                opd <= a;
                cnt <= (mag == 6'd0) ? 6'd1 : mag;
              end
            endcase
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
